// File: rtl/sync_fifo_core.sv
// ---------------------------------------------------------------------------
// sync_fifo_core
//   DEPTH x WIDTH register-array FIFO storage. One push and one pop may happen
//   in the same cycle. A push that arrives while the FIFO is full is accepted
//   only if a pop frees a slot in the same cycle; otherwise it is dropped
//   silently and nothing changes.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; empties the FIFO
//   wr_en    in   push request
//   wr_data  in   word to push
//   rd_en    in   pop request (ignored when empty)
//   rd_data  out  head word (combinational, valid while not empty)
//   empty    out  no words stored
//   full     out  DEPTH words stored
// ---------------------------------------------------------------------------
module sync_fifo_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic rd_acc;
    logic wr_acc;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign rd_data = mem_q[rd_ptr_q];

    // A write while full is only taken when a pop frees the head slot in the
    // same cycle; the pop reads the old head, so there is no overlap hazard.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (wr_acc) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage contents need no reset: they are unreachable while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sync_fifo_bypass.sv
// ---------------------------------------------------------------------------
// sync_fifo_bypass
//   Producer-side FIFO with a zero-storage bypass path toward an arbiter.
//   When granted and empty, a fresh write goes straight to the output
//   register; otherwise writes are queued and drained in write order.
//
// Ports
//   CLK       in   rising-edge clock
//   Reset     in   synchronous, active-high
//   i_WrEn    in   producer write strobe
//   i_WrData  in   producer data
//   i_Grant   in   arbiter grant for this cycle
//   o_Valid   out  registered; o_Data carries a new word
//   o_Data    out  registered output word, holds when o_Valid is low
//   o_Grant   out  combinational request: a word is available to send
// ---------------------------------------------------------------------------
module sync_fifo_bypass #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             i_WrEn,
    input  logic [WIDTH-1:0] i_WrData,
    input  logic             i_Grant,
    output logic             o_Valid,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Grant
);

    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_head;

    logic             bypass;
    logic             pop;
    logic             push;

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q,  o_data_d;

    // Must not look at i_Grant: the arbiter builds i_Grant from o_Grant.
    assign o_Grant = i_WrEn || !fifo_empty;

    // Stored words always win over a fresh write so ordering is preserved;
    // in that case the fresh write is queued behind them.
    assign pop    = i_Grant && !fifo_empty;
    assign bypass = i_Grant && fifo_empty && i_WrEn;
    assign push   = i_WrEn && !bypass;

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (CLK),
        .reset   (Reset),
        .wr_en   (push),
        .wr_data (i_WrData),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        o_valid_d = pop || bypass;
        o_data_d  = o_data_q;
        if (pop) begin
            o_data_d = fifo_head;
        end else if (bypass) begin
            o_data_d = i_WrData;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_Valid = o_valid_q;
    assign o_Data  = o_data_q;

    // Full is consumed inside the core; kept visible here for debug probing.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_sync_fifo_bypass.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_bypass
//   Self-checking bench: directed scenarios followed by random traffic, all
//   compared against a queue-based model of the producer/arbiter behaviour.
// ---------------------------------------------------------------------------
module tb_sync_fifo_bypass;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             CLK;
    logic             Reset;
    logic             i_WrEn;
    logic [WIDTH-1:0] i_WrData;
    logic             i_Grant;
    logic             o_Valid;
    logic [WIDTH-1:0] o_Data;
    logic             o_Grant;

    sync_fifo_bypass #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .i_WrEn   (i_WrEn),
        .i_WrData (i_WrData),
        .i_Grant  (i_Grant),
        .o_Valid  (o_Valid),
        .o_Data   (o_Data),
        .o_Grant  (o_Grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] mdl_q [$];
    logic             mdl_valid;
    logic [WIDTH-1:0] mdl_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational request, step the
    // model, clock, then check registered outputs and occupancy.
    task automatic cycle(input logic wr, input logic [WIDTH-1:0] d,
                         input logic g, input logic rst);
        i_WrEn   = wr;
        i_WrData = d;
        i_Grant  = g;
        Reset    = rst;
        #1;
        check("o_Grant", 32'(o_Grant), 32'(wr || (mdl_q.size() != 0)));

        if (rst) begin
            mdl_q.delete();
            mdl_valid = 1'b0;
            mdl_data  = '0;
        end else if (g) begin
            if (mdl_q.size() != 0) begin
                mdl_valid = 1'b1;
                mdl_data  = mdl_q.pop_front();
                if (wr) mdl_q.push_back(d);
            end else begin
                mdl_valid = wr;
                if (wr) mdl_data = d;
            end
        end else begin
            mdl_valid = 1'b0;
            if (wr && mdl_q.size() < DEPTH) mdl_q.push_back(d);
        end

        @(posedge CLK);
        #1;
        check("o_Valid", 32'(o_Valid), 32'(mdl_valid));
        check("o_Data",  32'(o_Data),  32'(mdl_data));
        check("count",   32'(dut.u_core.count_q), 32'(mdl_q.size()));
    endtask

    initial begin
        Reset    = 1'b1;
        i_WrEn   = 1'b0;
        i_WrData = '0;
        i_Grant  = 1'b0;
        mdl_valid = 1'b0;
        mdl_data  = '0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_valid", 32'(o_Valid), 32'd0);
        check("rst_data",  32'(o_Data),  32'd0);
        check("rst_grant", 32'(o_Grant), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Bypass: 1..4 with grant and empty FIFO.
        for (int i = 1; i <= 4; i++) cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Buffer: 5..8 with grant low.
        for (int i = 5; i <= 8; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        check("buf_count", 32'(dut.u_core.count_q), 32'd4);

        // Ordered drain while writing 9..12.
        for (int i = 9; i <= 12; i++) cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Seamless refill: 13..16 stored, 17 arrives as 16 pops.
        for (int i = 13; i <= 16; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 17; i <= 20; i++) cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Overflow: 1..9 with grant low, 9 is dropped.
        for (int i = 1; i <= 9; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        check("full_count", 32'(dut.u_core.count_q), 32'(DEPTH));
        // Write plus pop while full is accepted.
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Reset with 3 words stored, then a bypass write.
        for (int i = 1; i <= 3; i++) cycle(1'b1, WIDTH'(8'h30 + i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("post_rst_grant", 32'(o_Grant), 32'd0);
        cycle(1'b1, 8'h5C, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            logic wr, g, rst;
            wr  = ($urandom_range(0, 3) != 0);
            g   = ($urandom_range(0, 2) == 0) ? 1'b1 : (n[7] ? 1'b1 : 1'b0);
            rst = ($urandom_range(0, 127) == 0);
            cycle(wr, WIDTH'($urandom), g, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_bypass.md
SYNC_FIFO_BYPASS -- requirements
Module: sync_fifo_bypass

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 8, data bit width (>=1).
REQ-003 SHALL have port CLK  input  1  sole clock; all logic updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_WrEn  input  1  producer write strobe; one word per cycle when high.
REQ-006 SHALL have port i_WrData  input  WIDTH  producer data, sampled when i_WrEn high.
REQ-007 SHALL have port i_Grant  input  1  arbiter grant; the block may output a word in the current cycle.
REQ-008 SHALL have port o_Valid  output  1  registered; o_Data carries a new word this cycle.
REQ-009 SHALL have port o_Data  output  WIDTH  registered output word.
REQ-010 SHALL have port o_Grant  output  1  request to arbiter; the block has a word to send.

Function
REQ-011 o_Grant SHALL be combinational: i_WrEn OR (FIFO not empty); it SHALL NOT depend on i_Grant, because the arbiter derives i_Grant combinationally from o_Grant.
REQ-012 Bypass: i_Grant=1, FIFO empty, i_WrEn=1 -> next cycle o_Valid=1 and o_Data=i_WrData; nothing is stored (1-cycle latency).
REQ-013 Drain: i_Grant=1, FIFO non-empty -> pop head; next cycle o_Valid=1 and o_Data=head; if i_WrEn=1 the same cycle, i_WrData SHALL be pushed (count unchanged).
REQ-014 Hold: i_Grant=0 -> no output; next cycle o_Valid=0; if i_WrEn=1, i_WrData SHALL be pushed.
REQ-015 Idle: i_Grant=1, FIFO empty, i_WrEn=0 -> next cycle o_Valid=0.
REQ-016 Words SHALL leave in strict write order; bypass SHALL never overtake stored words.
REQ-017 When o_Valid=0, o_Data SHALL hold its last value.
REQ-018 Full (count=DEPTH): a write with no simultaneous pop SHALL be dropped silently with no state change; write plus pop when full SHALL be accepted.
REQ-019 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer MSB or an occupancy counter of width clog2(DEPTH)+1.
REQ-020 Back-to-back: when the last stored word pops in the same cycle a new write arrives, the new word SHALL be pushed and output next grant cycle with no gap on o_Valid.

Reset
REQ-021 With Reset high at a rising edge: o_Valid=0, o_Data=0, FIFO empty, pointers/count=0; inputs ignored that cycle.
REQ-022 Reset mid-operation SHALL discard all stored words; o_Grant then equals i_WrEn.

Structure
REQ-023 No shared package SHALL be required; DEPTH/WIDTH are module parameters and derived widths are local constants.
REQ-024 Storage SHALL be one sub-module, sync_fifo_core: DEPTH x WIDTH register array with wr_en, rd_en, empty and full; bypass/output logic stays in the top.

Verification
REQ-025 Bypass: grant high, FIFO empty, write 1,2,3,4 on consecutive cycles -> o_Valid high the 4 following cycles, o_Data 1,2,3,4; FIFO stays empty.
REQ-026 Buffer: grant low, write 5,6,7,8 -> o_Valid stays 0, o_Grant=1, FIFO count 4.
REQ-027 Ordered drain: grant high, write 9,10,11,12 -> o_Data 5,6,7,8,9,10,11,12 on 8 consecutive valid cycles, then FIFO empty and o_Grant=0.
REQ-028 Seamless refill: buffer 13..16 with grant low, raise grant, start writing 17..20 exactly as the FIFO drains -> o_Data 13..20 on 8 consecutive valid cycles.
REQ-029 Overflow: grant low, write 1..9 -> 9 dropped; grant high -> o_Data 1..8 only.
REQ-030 Reset: assert Reset with 3 words stored -> o_Valid=0, o_Data=0, o_Grant=0 with i_WrEn low; a following bypass write outputs after 1 cycle.
